snn_seq_ctrl: RTL and testbench
===============================

Name: snn_seq_ctrl

Overview:
- Top-level sequencer for one SNN inference.
- Accepts 98 UART bytes (784 pixels, 1 bit each, LSB first) and writes them bit-serially into the 1-bit x 1024 input RAM.
- Starts the SNN core, which then owns the RAM read port. Waits for the core to finish, then transmits the classified digit as one ASCII byte.
- Sits between uart_rx/uart_tx, the input RAM and the SNN core.

Parameters:
- NUM_PIXELS, 784, number of input bits per image; must be a multiple of 8.
- ADDR_W, 10, input RAM address width.
- TIMEOUT_CYCLES, 5_000_000, idle cycles tolerated between bytes mid-load. Only used with SNN_BYTE_TIMEOUT_EN; 100 ms at 50 MHz.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rx_rdy  in  1  uart_rx holds a received byte
- rx_data  in  8  received byte
- clr_rx_rdy  out  1  one-cycle pulse consuming rx_rdy
- ram_addr  out  ADDR_W  input RAM address
- ram_wdata  out  1  input RAM write data
- ram_we  out  1  input RAM write enable
- core_addr  in  ADDR_W  read address driven by the SNN core
- core_start  out  1  one-cycle start pulse to the core
- core_done  in  1  core finished; level, sampled only in RUN
- core_digit  in  4  classification result, 0..9, valid with core_done
- tx_rdy  in  1  uart_tx idle
- tx_start  out  1  one-cycle transmit pulse
- tx_data  out  8  byte to transmit
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, wr_addr=0, shift reg=0, result reg=0.
  - Registered outputs at reset: clr_rx_rdy=0, core_start=0, tx_start=0, tx_data=8'h00.
  - Combinational outputs at reset: ram_we=0, busy=0, ram_wdata=0.
- States: IDLE, SHIFT, WAIT_BYTE, START, RUN, TX, TX_WAIT.
- IDLE:
  - On rx_rdy: latch rx_data into the shift reg, pulse clr_rx_rdy next cycle, go to SHIFT.
  - wr_addr is 0 on entry.
- SHIFT, 8 cycles:
  - ram_we=1, ram_addr=wr_addr, ram_wdata=shift[0].
  - Each cycle: shift right, wr_addr++.
  - Leave when wr_addr[2:0]==7 is written. If that write was address NUM_PIXELS-1, go to START; otherwise go to WAIT_BYTE.
- WAIT_BYTE: on rx_rdy, latch, pulse clr_rx_rdy, go to SHIFT.
- Write latency: the byte at rx_rdy cycle N is fully written by cycle N+8.
- START:
  - Pulse core_start for one cycle, clear wr_addr to 0, go to RUN.
  - Total image load is 98x8 = 784 write cycles plus UART gaps.
- RUN:
  - On core_done, capture core_digit into the result reg, go to TX.
  - core_done seen in any state other than RUN is ignored.
- TX:
  - When tx_rdy=1: tx_data = 8'h30 + {4'h0, result}, pulse tx_start, go to TX_WAIT.
  - While tx_rdy=0: hold in TX.
- TX_WAIT: wait for tx_rdy to drop and return high, then go to IDLE.
- RAM address mux:
  - ram_addr = wr_addr in SHIFT only; core_addr in all other states.
  - ram_we is 0 outside SHIFT.
- Stray bytes: rx_rdy arriving in START/RUN/TX/TX_WAIT is discarded with a clr_rx_rdy pulse and is not written.
- Byte during SHIFT: rx_rdy is left pending and serviced in WAIT_BYTE/IDLE; it is never lost.
- wr_addr: ADDR_W wide, unsigned. It never exceeds NUM_PIXELS-1 while writing; no wrap occurs.
- Reset mid-load or mid-run: immediate return to IDLE with wr_addr=0; a partial image is abandoned.

Optional Feature:
- SNN_BYTE_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_BYTE and clears on each rx_rdy.
  - On reaching TIMEOUT_CYCLES: wr_addr=0, go to IDLE; the next byte is treated as pixel byte 0.
- Undefined: no counter; WAIT_BYTE waits indefinitely.

Decomposition:
- Package snn_pkg:
  - state_t enum.
  - NUM_PIXELS and ASCII_ZERO (8'h30) constants.
  - TIMEOUT_CYCLES default.
- One sub-module: snn_timeout_cnt (counter + terminal flag), instantiated only under the macro.
- The rest is one FSM with registered counters and combinational mux/outputs.

Test Plan:
- Byte 8'hA5 in IDLE -> ram_we high 8 cycles; addrs 0..7 get bits 1,0,1,0,0,1,0,1; clr_rx_rdy pulses once; state=WAIT_BYTE.
- 98 bytes of 8'hFF, spaced 20 cycles -> 784 writes to addrs 0..783; core_start pulses once, exactly one cycle after the last write; wr_addr=0.
- In RUN: core_addr=10'h123 -> ram_addr=10'h123, ram_we=0. core_done with digit 7 -> tx_data=8'h37, tx_start pulses once after tx_rdy=1.
- tx_rdy held low 100 cycles in TX -> no tx_start until tx_rdy rises; after the tx_rdy low/high cycle, busy=0 and the FSM is back in IDLE.
- Stray byte during RUN -> clr_rx_rdy pulses, no RAM write; next image still starts at addr 0.
- rst_n low after 40 bytes -> all outputs at reset values; the following byte writes addrs 0..7. With SNN_BYTE_TIMEOUT_EN and TIMEOUT_CYCLES=100: a 150-cycle gap after byte 3 -> IDLE, and byte 4 writes addr 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN inference sequencer.
package snn_pkg;

  localparam int unsigned NUM_PIXELS     = 784;
  localparam int unsigned ADDR_W         = 10;
  localparam int unsigned TIMEOUT_CYCLES = 5_000_000;
  localparam logic [7:0]  ASCII_ZERO     = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT_BYTE,
    ST_START,
    ST_RUN,
    ST_TX,
    ST_TX_WAIT
  } state_t;

  // Map a classification result 0..9 onto its ASCII character.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/snn_timeout_cnt.sv
// Idle-cycle counter with a registered terminal flag; guards the gap between
// pixel bytes when SNN_BYTE_TIMEOUT_EN is defined.
module snn_timeout_cnt #(
  parameter int unsigned CNT_MAX = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q,  tc_d;

  // Count enabled cycles; flag and saturate once CNT_MAX cycles have elapsed.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = tc_q;
    if (clr_i) begin
      cnt_d = '0;
      tc_d  = 1'b0;
    end else if (en_i && !tc_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      tc_d  = (cnt_q == CNT_W'(CNT_MAX - 1));
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/snn_seq_ctrl.sv
// Sequencer for one SNN inference: loads a bit-packed image from the UART into
// the input RAM, starts the core, and returns the digit as an ASCII byte.
// Optional: define SNN_BYTE_TIMEOUT_EN to abandon a partial image after
// TIMEOUT_CYCLES idle cycles between bytes.
module snn_seq_ctrl #(
  parameter int unsigned NUM_PIXELS = snn_pkg::NUM_PIXELS,
  parameter int unsigned ADDR_W     = snn_pkg::ADDR_W
`ifdef SNN_BYTE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = snn_pkg::TIMEOUT_CYCLES
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              ram_we,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  input  logic              tx_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy
);

  import snn_pkg::*;

  state_t            state_q,       state_d;
  logic [ADDR_W-1:0] wr_addr_q,     wr_addr_d;
  logic [7:0]        shift_q,       shift_d;
  logic [3:0]        result_q,      result_d;
  logic              clr_rx_rdy_q,  clr_rx_rdy_d;
  logic              core_start_q,  core_start_d;
  logic              tx_start_q,    tx_start_d;
  logic [7:0]        tx_data_q,     tx_data_d;
  logic              tx_low_seen_q, tx_low_seen_d;

  logic rx_take_c;
  logic byte_end_c;
  logic last_pixel_c;
  logic timeout_c;

  // rx_rdy is still high in the cycle our clear pulse is out; don't take it twice.
  assign rx_take_c    = rx_rdy & ~clr_rx_rdy_q;
  assign byte_end_c   = (wr_addr_q[2:0] == 3'd7);
  assign last_pixel_c = (wr_addr_q == ADDR_W'(NUM_PIXELS - 1));

`ifdef SNN_BYTE_TIMEOUT_EN
  logic tmo_clr_c;
  logic tmo_en_c;

  assign tmo_en_c  = (state_q == ST_WAIT_BYTE);
  assign tmo_clr_c = rx_rdy | ~tmo_en_c;

  snn_timeout_cnt #(
    .CNT_MAX (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmo_clr_c),
    .en_i  (tmo_en_c),
    .tc_o  (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state logic, RAM port mux and registered-output next values.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    shift_d       = shift_q;
    result_d      = result_q;
    clr_rx_rdy_d  = 1'b0;
    core_start_d  = 1'b0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    tx_low_seen_d = tx_low_seen_q;
    ram_we        = 1'b0;
    ram_wdata     = 1'b0;
    ram_addr      = core_addr;
    busy          = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        wr_addr_d = '0;
        if (rx_take_c) begin
          shift_d      = rx_data;
          clr_rx_rdy_d = 1'b1;
          state_d      = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        ram_we    = 1'b1;
        ram_addr  = wr_addr_q;
        ram_wdata = shift_q[0];
        shift_d   = {1'b0, shift_q[7:1]};
        if (byte_end_c && last_pixel_c) begin
          // Raise start here so the pulse is visible during the START cycle.
          core_start_d = 1'b1;
          state_d      = ST_START;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (byte_end_c) begin
            state_d = ST_WAIT_BYTE;
          end
        end
      end

      ST_WAIT_BYTE: begin
        if (rx_take_c) begin
          shift_d      = rx_data;
          clr_rx_rdy_d = 1'b1;
          state_d      = ST_SHIFT;
        end else if (timeout_c) begin
          wr_addr_d = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_START: begin
        clr_rx_rdy_d = rx_take_c;
        wr_addr_d    = '0;
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        clr_rx_rdy_d = rx_take_c;
        if (core_done) begin
          result_d = core_digit;
          state_d  = ST_TX;
        end
      end

      ST_TX: begin
        clr_rx_rdy_d = rx_take_c;
        if (tx_rdy) begin
          tx_data_d     = digit_to_ascii(result_q);
          tx_start_d    = 1'b1;
          tx_low_seen_d = 1'b0;
          state_d       = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        clr_rx_rdy_d = rx_take_c;
        if (!tx_rdy) begin
          tx_low_seen_d = 1'b1;
        end else if (tx_low_seen_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_addr_q     <= '0;
      shift_q       <= '0;
      result_q      <= '0;
      clr_rx_rdy_q  <= 1'b0;
      core_start_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_low_seen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      shift_q       <= shift_d;
      result_q      <= result_d;
      clr_rx_rdy_q  <= clr_rx_rdy_d;
      core_start_q  <= core_start_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      tx_low_seen_q <= tx_low_seen_d;
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign core_start = core_start_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Directed bench for snn_seq_ctrl with simple uart_rx/uart_tx/RAM models.
module tb_snn_seq_ctrl;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned NUM_PIXELS = 784;

  logic              clk;
  logic              rst_n;
  logic              rx_rdy = 1'b0;
  logic              rx_set;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic              ram_we;
  logic [ADDR_W-1:0] core_addr;
  logic              core_start;
  logic              core_done;
  logic [3:0]        core_digit;
  logic              tx_rdy;
  logic              tx_hold;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;

  snn_seq_ctrl #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
`ifdef SNN_BYTE_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .core_addr  (core_addr),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_rdy     (tx_rdy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_rx model: byte held until cleared
  always @(posedge clk) begin
    if (rx_set) rx_rdy <= 1'b1;
    else if (clr_rx_rdy) rx_rdy <= 1'b0;
  end

  // uart_tx model: busy 10 cycles per byte, optionally forced not-ready
  int tx_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) tx_cnt <= 10;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_rdy = !tx_hold && (tx_cnt == 0);

  // RAM model and event monitors
  logic        mem [1024];
  int          wr_cnt = 0, cs_cnt = 0, cs_cyc = 0, clr_cnt = 0, txs_cnt = 0, last_wr_cyc = 0;
  logic [9:0]  last_wr_addr = '0;
  logic [7:0]  txs_data = '0;
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_wr_cyc   <= cyc;
      last_wr_addr  <= ram_addr;
    end
    if (core_start === 1'b1) begin
      cs_cnt <= cs_cnt + 1;
      cs_cyc <= cyc;
    end
    if (clr_rx_rdy === 1'b1) clr_cnt <= clr_cnt + 1;
    if (tx_start === 1'b1) begin
      txs_cnt  <= txs_cnt + 1;
      txs_data <= tx_data;
    end
  end

  typedef struct { logic [9:0] addr; logic exp_bit; } bit_vec_t;
  typedef struct { logic [9:0] core_addr; logic [9:0] exp_addr; logic exp_we; logic exp_busy; } mux_vec_t;
  typedef struct { logic [3:0] digit; logic [7:0] exp_tx; logic [7:0] fill; } dig_vec_t;

  int nvec = 0;
  int nerr = 0;
  int w0, c0, s0, t0, ones;
  logic [7:0] pat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_set  = 1'b1;
    tick(1);
    rx_set  = 1'b0;
  endtask

  task automatic load_bytes(input int n, input logic [7:0] b, input int gap);
    for (int i = 0; i < n; i++) begin
      send_byte(b);
      tick(gap - 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clr"},   32'(clr_rx_rdy), 32'd0);
    chk({tag, "_cs"},    32'(core_start), 32'd0);
    chk({tag, "_txs"},   32'(tx_start),   32'd0);
    chk({tag, "_txd"},   32'(tx_data),    32'h00);
    chk({tag, "_we"},    32'(ram_we),     32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_wdata"}, 32'(ram_wdata),  32'd0);
  endtask

  // Wait for core_start, return a digit, check the ASCII byte and return to IDLE.
  task automatic finish_run(input logic [3:0] digit, input logic [7:0] exp_tx);
    int s_before, t_before;
    s_before = cs_cnt - 1;
    for (int i = 0; i < 300 && cs_cnt == s_before; i++) tick(1);
    t_before = txs_cnt;
    tick(2);
    core_digit = digit;
    core_done  = 1'b1;
    tick(1);
    core_done  = 1'b0;
    core_digit = 4'hF;
    for (int i = 0; i < 50 && txs_cnt == t_before; i++) tick(1);
    chk("run_txs_cnt", 32'(txs_cnt - t_before), 32'd1);
    chk("run_tx_data", 32'(txs_data), 32'(exp_tx));
    for (int i = 0; i < 50 && busy !== 1'b0; i++) tick(1);
    chk("run_idle", 32'(busy), 32'd0);
  endtask

  bit_vec_t bit_tab [8];
  mux_vec_t mux_tab [4];
  dig_vec_t dig_tab [3];

  initial begin
    bit_tab = '{'{10'd0, 1'b1}, '{10'd1, 1'b0}, '{10'd2, 1'b1}, '{10'd3, 1'b0},
                '{10'd4, 1'b0}, '{10'd5, 1'b1}, '{10'd6, 1'b0}, '{10'd7, 1'b1}};
    mux_tab = '{'{10'h123, 10'h123, 1'b0, 1'b1}, '{10'h000, 10'h000, 1'b0, 1'b1},
                '{10'h3FF, 10'h3FF, 1'b0, 1'b1}, '{10'h2AA, 10'h2AA, 1'b0, 1'b1}};
    dig_tab = '{'{4'd0, 8'h30, 8'h00}, '{4'd9, 8'h39, 8'h81}, '{4'd3, 8'h33, 8'h3C}};

    rst_n = 1'b1; rx_set = 1'b0; rx_data = 8'h00; core_addr = 10'h055;
    core_done = 1'b0; core_digit = 4'h0; tx_hold = 1'b0;
    #5 rst_n = 1'b0;
    tick(3);
    chk_reset_outputs("reset");
    chk("reset_ram_addr", 32'(ram_addr), 32'h055);
    rst_n = 1'b1;
    tick(2);

    // core_done outside RUN is ignored
    core_done = 1'b1; core_digit = 4'd5;
    tick(3);
    core_done = 1'b0;
    tick(3);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_txs", 32'(txs_cnt), 32'd0);

    // First byte 0xA5: eight writes, LSB first
    w0 = wr_cnt; c0 = clr_cnt; s0 = cs_cnt;
    send_byte(8'hA5);
    tick(19);
    chk("a5_writes", 32'(wr_cnt - w0), 32'd8);
    chk("a5_clr", 32'(clr_cnt - c0), 32'd1);
    chk("a5_busy", 32'(busy), 32'd1);
    chk("a5_we_off", 32'(ram_we), 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("a5_bit%0d", i), 32'(mem[bit_tab[i].addr]), 32'(bit_tab[i].exp_bit));

    // Remaining 97 bytes of 0xFF, 20 cycles apart
    load_bytes(97, 8'hFF, 20);
    for (int i = 0; i < 200 && cs_cnt == s0; i++) tick(1);
    tick(5);
    chk("img_writes", 32'(wr_cnt - w0), 32'd784);
    chk("img_last_addr", 32'(last_wr_addr), 32'd783);
    chk("img_cs_cnt", 32'(cs_cnt - s0), 32'd1);
    chk("img_cs_lat", 32'(cs_cyc - last_wr_cyc), 32'd1);
    ones = 0;
    for (int a = 8; a < 784; a++) ones += int'(mem[a]);
    chk("img_ones", 32'(ones), 32'd776);

    // RUN: core owns the RAM address
    for (int i = 0; i < 4; i++) begin
      core_addr = mux_tab[i].core_addr;
      #1;
      chk($sformatf("mux_addr%0d", i), 32'(ram_addr), 32'(mux_tab[i].exp_addr));
      chk($sformatf("mux_we%0d", i),   32'(ram_we),   32'(mux_tab[i].exp_we));
      chk($sformatf("mux_busy%0d", i), 32'(busy),     32'(mux_tab[i].exp_busy));
    end

    // Stray byte during RUN is consumed and dropped
    w0 = wr_cnt; c0 = clr_cnt;
    send_byte(8'h3C);
    tick(6);
    chk("stray_clr", 32'(clr_cnt - c0), 32'd1);
    chk("stray_writes", 32'(wr_cnt - w0), 32'd0);
    chk("stray_rx_rdy", 32'(rx_rdy), 32'd0);
    chk("stray_busy", 32'(busy), 32'd1);

    // Digit 7 with uart_tx held busy for 100 cycles
    tx_hold = 1'b1;
    t0 = txs_cnt;
    core_digit = 4'd7; core_done = 1'b1;
    tick(1);
    core_done = 1'b0; core_digit = 4'h0;
    tick(100);
    chk("hold_no_txs", 32'(txs_cnt - t0), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    tx_hold = 1'b0;
    for (int i = 0; i < 20 && txs_cnt == t0; i++) tick(1);
    chk("tx7_cnt", 32'(txs_cnt - t0), 32'd1);
    chk("tx7_data", 32'(txs_data), 32'h37);
    for (int i = 0; i < 50 && busy !== 1'b0; i++) tick(1);
    chk("tx7_idle", 32'(busy), 32'd0);
    tick(5);
    chk("tx7_single", 32'(txs_cnt - t0), 32'd1);

    // Digit table; first image begins with 0x96 and must restart at addr 0
    for (int v = 0; v < 3; v++) begin
      w0 = wr_cnt;
      if (v == 0) begin
        pat = 8'h96;
        send_byte(pat);
        tick(12);
        chk("next_last_addr", 32'(last_wr_addr), 32'd7);
        chk("next_writes", 32'(wr_cnt - w0), 32'd8);
        for (int i = 0; i < 8; i++)
          chk($sformatf("next_bit%0d", i), 32'(mem[i]), 32'(pat[i]));
        load_bytes(97, dig_tab[v].fill, 12);
      end else begin
        load_bytes(98, dig_tab[v].fill, 12);
      end
      chk($sformatf("dig%0d_writes", v), 32'(wr_cnt - w0), 32'd784);
      finish_run(dig_tab[v].digit, dig_tab[v].exp_tx);
    end

    // Reset part-way through a load
    load_bytes(40, 8'h5A, 12);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    w0 = wr_cnt;
    send_byte(8'h0F);
    tick(12);
    chk("midrst_last_addr", 32'(last_wr_addr), 32'd7);
    chk("midrst_writes", 32'(wr_cnt - w0), 32'd8);
    chk("midrst_bit0", 32'(mem[0]), 32'd1);
    chk("midrst_bit7", 32'(mem[7]), 32'd0);

    // Long gap after the third byte
    load_bytes(2, 8'h00, 12);
    tick(150);
`ifdef SNN_BYTE_TIMEOUT_EN
    chk("gap_busy", 32'(busy), 32'd0);
`else
    chk("gap_busy", 32'(busy), 32'd1);
`endif
    send_byte(8'hF0);
    tick(12);
`ifdef SNN_BYTE_TIMEOUT_EN
    chk("gap_last_addr", 32'(last_wr_addr), 32'd7);
    chk("gap_bit4", 32'(mem[4]), 32'd1);
`else
    chk("gap_last_addr", 32'(last_wr_addr), 32'd31);
    chk("gap_bit4", 32'(mem[28]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
